hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline stall/flush controller for the 5-stage MIPS core: the producer side of forwarding, covering the hazards that forwarding cannot resolve.
- Detects load-use dependences, data-memory waits, taken branches/jumps and halt, and drives per-latch enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB plus the PC enable.
- Owns a small FSM that guarantees exactly-one-bubble load-use handling, and keeps saturating stall/flush event counters for performance debug.

Parameters:
- CNT_W, 32, width of stall_cnt and flush_cnt.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- idex_dREN  in  1  instruction in ID/EX is a load.
- idex_wsel  in  5  destination register of the ID/EX instruction.
- ifid_rs  in  5  rs field of the IF/ID instruction.
- ifid_rt  in  5  rt field of the IF/ID instruction.
- exm_dREN  in  1  load in EX/MEM.
- exm_dWEN  in  1  store in EX/MEM.
- exm_pcsrc  in  1  taken branch or jump resolved in EX/MEM.
- exm_halt  in  1  halt in EX/MEM.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exm_en, mwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exm_flush, mwb_flush  out  1 each  synchronous bubble insert (latch loads nop).
- halted  out  1  registered; core stopped.
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted.
- flush_cnt  out  CNT_W  number of branch/jump redirects.

Behaviour:
- States: RUN, LOADUSE, MEMWAIT, HALT. State, halted and counters are registered; enables/flushes are combinational from state and inputs.
- Reset (nRST=0, asynchronous): state=RUN, halted=0, stall_cnt=0, flush_cnt=0. All enables and flushes are forced to 0 while nRST is low.
- Definitions:
  - mem_busy = (exm_dREN | exm_dWEN) & ~dhit.
  - lu_hazard = idex_dREN & (idex_wsel != 0) & (idex_wsel == ifid_rs | idex_wsel == ifid_rt).
- Priority, same cycle: halt > mem_busy > exm_pcsrc > lu_hazard > normal.
- RUN, normal: all stage enables = 1, pc_en = ihit.
  - If ~ihit: ifid_flush = 1 and later stages still advance.
- RUN, exm_halt: pc_en = ifid_en = idex_en = exm_en = 0, mwb_en = 1; next state HALT.
- RUN, mem_busy: pc_en = ifid_en = idex_en = exm_en = 0, mwb_flush = 1 (prevents a duplicate WB write); next state MEMWAIT.
- RUN, exm_pcsrc (no mem_busy):
  - Enables = 1; ifid_flush = idex_flush = exm_flush = 1; pc_en = 1 regardless of ihit (redirect must load).
  - flush_cnt += 1. Next state RUN.
- RUN, lu_hazard:
  - pc_en = ifid_en = 0; idex_flush = 1 (bubble); exm_en = mwb_en = 1.
  - Next state LOADUSE.
- LOADUSE:
  - lu_hazard is ignored this cycle; the bubble is already in EX and forwarding covers MEM->EX. Behave as RUN-normal otherwise, honouring higher-priority events.
  - Next state RUN, or MEMWAIT/HALT per priority.
- MEMWAIT: same outputs as the mem_busy case while ~dhit.
  - On dhit: exm_en = mwb_en = 1 and all other enables = 1, with the normal ihit gating; next state RUN.
  - exm_pcsrc is not acted on until dhit arrives.
- HALT: all enables 0, all flushes 0, halted = 1; sticky until reset.
- stall_cnt increments on every clock edge where state != HALT and pc_en = 0. Both counters saturate at all-ones and never wrap.
- exm_pcsrc with lu_hazard in the same cycle: the flush wins and no LOADUSE entry occurs, because the dependent instruction is being flushed.
- lu_hazard with idex_wsel = 0 is never a hazard.
- Reset asserted mid-MEMWAIT or mid-LOADUSE returns to RUN immediately. Counters clear.

Test Plan:
- Reset: nRST=0 -> all enables 0, halted=0, counters 0. Release with ihit=1 -> all enables 1, pc_en=1.
- lw $3 then add $4,$3,$5 (idex_dREN=1, idex_wsel=3, ifid_rs=3) -> one cycle with pc_en=0, ifid_en=0, idex_flush=1, then RUN. stall_cnt=1. The same pattern with idex_wsel=0 -> no stall.
- Store in EX/MEM with dhit low for 3 cycles -> pc_en/exm_en held 0 and mwb_flush=1 for 3 cycles. On the dhit cycle all enables = 1. stall_cnt=3 plus the dhit-cycle value.
- exm_pcsrc=1 together with lu_hazard=1 -> ifid/idex/exm flush = 1, pc_en=1, no LOADUSE state. flush_cnt increments by 1.
- exm_halt=1 -> halted=1 next edge. Enables stay 0 for 10+ cycles despite ihit/dhit toggling. stall_cnt does not change after HALT.
- With CNT_W=4, force 20 stall cycles -> stall_cnt=15 and holds (saturates, no wrap).

Source files
------------

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, data-memory waits,
// branch/jump redirects and halt, with saturating stall and flush event counters.
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_wsel,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             exm_dREN,
    input  logic             exm_dWEN,
    input  logic             exm_pcsrc,
    input  logic             exm_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exm_en,
    output logic             mwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exm_flush,
    output logic             mwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // state   | meaning
    // RUN     | normal issue, all hazards evaluated
    // LOADUSE | bubble already inserted; load-use check suppressed for one cycle
    // MEMWAIT | data access outstanding, front of pipe frozen until dhit
    // HALT    | core stopped, sticky until reset
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] LOADUSE = 2'd1;
    localparam logic [1:0] MEMWAIT = 2'd2;
    localparam logic [1:0] HALT    = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       mem_busy;
    logic       lu_hazard;
    logic       redirect;

    assign mem_busy  = (exm_dREN | exm_dWEN) & ~dhit;
    assign lu_hazard = idex_dREN & (idex_wsel != 5'd0) &
                       ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exm_en     = 1'b0;
        mwb_en     = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exm_flush  = 1'b0;
        mwb_flush  = 1'b0;
        redirect   = 1'b0;
        next_state = state;
        if (nRST && state != HALT) begin
            if ((state == MEMWAIT && !dhit) || (state != MEMWAIT && !exm_halt && mem_busy)) begin
                // WB latch takes a nop so the stalled MEM instruction is not written back twice
                mwb_en     = 1'b1;
                mwb_flush  = 1'b1;
                next_state = MEMWAIT;
            end else if (exm_halt) begin
                mwb_en     = 1'b1;
                next_state = HALT;
            end else if (exm_pcsrc) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exm_en     = 1'b1;
                mwb_en     = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                exm_flush  = 1'b1;
                redirect   = 1'b1;
                next_state = RUN;
            end else if (lu_hazard && state == RUN) begin
                idex_en    = 1'b1;
                exm_en     = 1'b1;
                mwb_en     = 1'b1;
                idex_flush = 1'b1;
                next_state = LOADUSE;
            end else begin
                pc_en      = ihit;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exm_en     = 1'b1;
                mwb_en     = 1'b1;
                ifid_flush = ~ihit;
                next_state = RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state == HALT) begin
                halted <= 1'b1;
            end
            if (state != HALT && !pc_en && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations, then random traffic
// compared every cycle against an action-based behavioural model.
module tb_hazard_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0, dhit = 1'b0, idex_dREN = 1'b0;
    logic [4:0]  idex_wsel = '0, ifid_rs = '0, ifid_rt = '0;
    logic        exm_dREN = 1'b0, exm_dWEN = 1'b0, exm_pcsrc = 1'b0, exm_halt = 1'b0;

    logic        pc_en, ifid_en, idex_en, exm_en, mwb_en;
    logic        ifid_flush, idex_flush, exm_flush, mwb_flush, halted;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_idex_en, s_exm_en, s_mwb_en;
    logic        s_ifid_flush, s_idex_flush, s_exm_flush, s_mwb_flush, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 CLK = ~CLK;

    hazard_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .idex_dREN(idex_dREN),
        .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exm_dREN(exm_dREN), .exm_dWEN(exm_dWEN), .exm_pcsrc(exm_pcsrc), .exm_halt(exm_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exm_en(exm_en), .mwb_en(mwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exm_flush(exm_flush),
        .mwb_flush(mwb_flush), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .idex_dREN(idex_dREN),
        .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exm_dREN(exm_dREN), .exm_dWEN(exm_dWEN), .exm_pcsrc(exm_pcsrc), .exm_halt(exm_halt),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exm_en(s_exm_en),
        .mwb_en(s_mwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exm_flush(s_exm_flush), .mwb_flush(s_mwb_flush), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {A_OFF, A_HALT, A_MEMSTALL, A_REDIRECT, A_BUBBLE, A_NORMAL} act_t;

    bit     m_halted, m_waiting, m_bubbled;
    longint m_stall, m_flush;

    function automatic act_t decide();
        if (!nRST || m_halted) return A_OFF;
        if (m_waiting && !dhit) return A_MEMSTALL;
        if (exm_halt) return A_HALT;
        if ((exm_dREN || exm_dWEN) && !dhit) return A_MEMSTALL;
        if (exm_pcsrc) return A_REDIRECT;
        if (!m_waiting && !m_bubbled && idex_dREN && idex_wsel != 0 &&
            (idex_wsel == ifid_rs || idex_wsel == ifid_rt)) return A_BUBBLE;
        return A_NORMAL;
    endfunction

    // bit order: pc, ifid_en, idex_en, exm_en, mwb_en, ifid_f, idex_f, exm_f, mwb_f
    function automatic logic [8:0] outs(input act_t a);
        case (a)
            A_HALT:     return 9'b000010000;
            A_MEMSTALL: return 9'b000010001;
            A_REDIRECT: return 9'b111111110;
            A_BUBBLE:   return 9'b001110100;
            A_NORMAL:   return {ihit, 4'b1111, ~ihit, 3'b000};
            default:    return 9'b0;
        endcase
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        act_t a;
        if (!nRST) begin
            m_halted = 0; m_waiting = 0; m_bubbled = 0; m_stall = 0; m_flush = 0;
        end else if (!m_halted) begin
            a = decide();
            if (outs(a)[8] == 1'b0) m_stall++;
            if (a == A_REDIRECT) m_flush++;
            m_waiting = (a == A_MEMSTALL);
            m_bubbled = (a == A_BUBBLE);
            if (a == A_HALT) m_halted = 1;
        end
    end

    always @(negedge CLK) begin
        chk("ctl", {pc_en, ifid_en, idex_en, exm_en, mwb_en,
                    ifid_flush, idex_flush, exm_flush, mwb_flush}, outs(decide()));
        chk("halted", halted, m_halted);
        chk("stall_cnt", stall_cnt, sat(m_stall, 64'hFFFF_FFFF));
        chk("flush_cnt", flush_cnt, sat(m_flush, 64'hFFFF_FFFF));
        chk("stall_cnt4", s_stall_cnt, sat(m_stall, 15));
        chk("flush_cnt4", s_flush_cnt, sat(m_flush, 15));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1; dhit = 0; idex_dREN = 0; idex_wsel = 0; ifid_rs = 0; ifid_rt = 0;
        exm_dREN = 0; exm_dWEN = 0; exm_pcsrc = 0; exm_halt = 0;
    endtask

    task automatic do_reset();
        nRST = 0;
        idle_inputs();
        step();
        nRST = 1;
    endtask

    function automatic logic [8:0] ctl_now();
        return {pc_en, ifid_en, idex_en, exm_en, mwb_en, ifid_flush, idex_flush, exm_flush, mwb_flush};
    endfunction

    initial begin
        int halt_age;
        idle_inputs();
        nRST = 0;
        step(); step(); #1;
        chk("rst_ctl", ctl_now(), 9'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        nRST = 1; #1;
        chk("release_ctl", ctl_now(), 9'b111110000);
        step();

        // load-use: lw $3 ; add $4,$3,$5
        do_reset();
        idex_dREN = 1; idex_wsel = 5'd3; ifid_rs = 5'd3; ifid_rt = 5'd7; #1;
        chk("lu_ctl", ctl_now(), 9'b001110100);
        step(); #1;
        chk("lu_next_ctl", ctl_now(), 9'b111110000);
        step(); idle_inputs(); #1;
        chk("lu_stall", stall_cnt, 1);
        idex_dREN = 1; idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; #1;
        chk("lu_r0_ctl", ctl_now(), 9'b111110000);
        step(); idle_inputs(); #1;
        chk("lu_r0_stall", stall_cnt, 1);

        // store waiting three cycles on dhit
        do_reset();
        exm_dWEN = 1; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_ctl", ctl_now(), 9'b000010001);
            step();
        end
        dhit = 1; #1;
        chk("mw_dhit_ctl", ctl_now(), 9'b111110000);
        step(); idle_inputs(); #1;
        chk("mw_stall", stall_cnt, 3);

        // redirect together with load-use: flush wins, no bubble state
        do_reset();
        exm_pcsrc = 1; idex_dREN = 1; idex_wsel = 5'd5; ifid_rs = 5'd5; #1;
        chk("br_lu_ctl", ctl_now(), 9'b111111110);
        step(); exm_pcsrc = 0; #1;
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_still_run", ctl_now(), 9'b001110100);
        step(); idle_inputs();

        // halt is sticky
        do_reset();
        exm_halt = 1; #1;
        chk("halt_ctl", ctl_now(), 9'b000010000);
        chk("halt_pre", halted, 1'b0);
        step(); exm_halt = 0; #1;
        chk("halt_set", halted, 1'b1);
        for (int i = 0; i < 12; i++) begin
            ihit = 1'($urandom); dhit = 1'($urandom); exm_pcsrc = 1'($urandom); #1;
            chk("halt_ctl_hold", ctl_now(), 9'b0);
            step();
        end
        #1;
        chk("halt_stall", stall_cnt, 1);
        chk("halt_sticky", halted, 1'b1);

        // saturation on the narrow instance
        do_reset();
        ihit = 0;
        repeat (20) step();
        #1;
        chk("sat_wide", stall_cnt, 20);
        chk("sat_narrow", s_stall_cnt, 4'd15);

        // reset in the middle of a memory wait
        do_reset();
        exm_dWEN = 1; dhit = 0;
        step(); step();
        nRST = 0; #1;
        chk("midrst_ctl", ctl_now(), 9'b0);
        chk("midrst_stall", stall_cnt, 0);
        idle_inputs(); nRST = 1; #1;
        chk("midrst_run", ctl_now(), 9'b111110000);
        step();

        // random traffic
        halt_age = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(149) == 0 || halt_age > 20) begin
                nRST = 0;
                halt_age = 0;
            end else begin
                nRST = 1;
            end
            ihit      = ($urandom_range(7) != 0);
            dhit      = ($urandom_range(2) == 0);
            idex_dREN = ($urandom_range(2) == 0);
            idex_wsel = 5'($urandom_range(3));
            ifid_rs   = 5'($urandom_range(3));
            ifid_rt   = 5'($urandom_range(3));
            exm_dREN  = ($urandom_range(5) == 0);
            exm_dWEN  = ($urandom_range(7) == 0);
            exm_pcsrc = ($urandom_range(9) == 0);
            exm_halt  = ($urandom_range(299) == 0);
            if (m_halted) halt_age++;
            step();
        end
        nRST = 1;
        idle_inputs();
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
